// File: rtl/mem_if_pkg.sv
// Shared types and sizing helpers for the memory interface front end.
package mem_if_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ACCESS = 2'd1,
        WR_ACCESS = 2'd2
    } state_e;

    // Width of a down-counter that must hold WAIT_CYCLES-1 without underflow.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_if_reg.sv
// Parameterised-width register with asynchronous clear and load enable.
module mem_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] reg_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            reg_q <= '0;
        else if (load)
            reg_q <= d;
    end

    assign q = reg_q;

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR front end that sequences control-unit requests into fixed-length RAM accesses.
module mem_interface
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_mux_out,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic              idle;
    logic              capture;
    logic              mdr_load;
    logic [DATA_W-1:0] mdr_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;

    assign idle     = (state_q == IDLE);
    assign capture  = (state_q == RD_ACCESS) && (cnt_q == '0);
    assign mdr_load = (mdr_in && idle) || capture;
    assign mdr_d    = capture ? mem_data_in : bus_mux_out;

    mem_reg #(.W(ADDR_W)) u_mar (
        .clock (clock),
        .clear (clear),
        .load  (mar_in && idle),
        .d     (bus_mux_out[ADDR_W-1:0]),
        .q     (mar_q)
    );

    mem_reg #(.W(DATA_W)) u_mdr (
        .clock (clock),
        .clear (clear),
        .load  (mdr_load),
        .d     (mdr_d),
        .q     (mdr_q)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Read wins over a simultaneous write; the write is dropped.
                if (read_req) begin
                    state_d = RD_ACCESS;
                    cnt_d   = CNT_LOAD;
                end else if (write_req) begin
                    state_d = WR_ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            RD_ACCESS, WR_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables decode from state alone; the async clear forces IDLE immediately.
    assign mem_re       = (state_q == RD_ACCESS);
    assign mem_we       = (state_q == WR_ACCESS);
    assign mem_addr     = mar_q;
    assign mem_data_out = mdr_q;
    assign mdr_out      = mdr_q;
    assign busy         = !idle;
    assign done         = done_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with a done-driven scoreboard on MDR contents.
module tb_mem_interface;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic              clock = 1'b0;
    logic              clear;
    logic [DATA_W-1:0] bus_mux_out;
    logic              mar_in, mdr_in, read_req, write_req;
    logic [DATA_W-1:0] mem_data_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re, mem_we;
    logic [DATA_W-1:0] mem_data_out, mdr_out;
    logic              busy, done;

    logic [DATA_W-1:0] ram [512];
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [DATA_W-1:0] last_wr_data = '0;

    logic [DATA_W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    mem_interface #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut (
        .clock        (clock),
        .clear        (clear),
        .bus_mux_out  (bus_mux_out),
        .mar_in       (mar_in),
        .mdr_in       (mdr_in),
        .read_req     (read_req),
        .write_req    (write_req),
        .mem_data_in  (mem_data_in),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out),
        .mdr_out      (mdr_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    // RAM read port; writes are only observed, not stored.
    assign mem_data_in = ram[mem_addr];

    always @(posedge clock) begin
        if (mem_we) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_data_out;
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at %0t, expected no pending access", $time);
            end else begin
                check("sb_mdr_at_done", mdr_out, exp_q.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[9'h105] = 32'hDEAD_BEEF;
        ram[9'h010] = 32'hCAFE_F00D;
        ram[9'h0AA] = 32'h0BAD_0BAD;
        ram[9'h003] = 32'h0000_0333;

        clear = 1'b1; bus_mux_out = '0;
        mar_in = 1'b0; mdr_in = 1'b0; read_req = 1'b0; write_req = 1'b0;
        repeat (2) cycle();
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_flags", {28'h0, busy, done, mem_re, mem_we}, 32'h0);
        clear = 1'b0;
        cycle();

        // Read path at 0x105.
        bus_mux_out = 32'h0000_0105; mar_in = 1'b1;
        cycle();
        mar_in = 1'b0;
        check("rd_mar", 32'(mem_addr), 32'h105);
        read_req = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
        cycle();
        read_req = 1'b0;
        check("rd_c1_flags", {29'h0, busy, mem_re, mem_we}, 32'h6);
        check("rd_c1_addr", 32'(mem_addr), 32'h105);
        cycle();
        check("rd_c2_flags", {29'h0, busy, mem_re, mem_we}, 32'h6);
        cycle();
        check("rd_done_flags", {28'h0, busy, done, mem_re, mem_we}, 32'h4);
        check("rd_mdr", mdr_out, 32'hDEAD_BEEF);
        cycle();
        check("rd_done_pulse", 32'(done), 32'h0);

        // Write path 0x1234_5678 -> 0x1FF.
        bus_mux_out = 32'h0000_01FF; mar_in = 1'b1;
        cycle();
        mar_in = 1'b0; bus_mux_out = 32'h1234_5678; mdr_in = 1'b1;
        cycle();
        mdr_in = 1'b0; write_req = 1'b1; exp_q.push_back(32'h1234_5678);
        cycle();
        write_req = 1'b0;
        check("wr_c1_flags", {29'h0, busy, mem_re, mem_we}, 32'h5);
        check("wr_addr", 32'(mem_addr), 32'h1FF);
        check("wr_data", mem_data_out, 32'h1234_5678);
        cycle();
        check("wr_c2_we", 32'(mem_we), 32'h1);
        cycle();
        check("wr_done_flags", {28'h0, busy, done, mem_re, mem_we}, 32'h4);
        check("wr_count", 32'(wr_cnt), 32'd2);
        check("wr_last", last_wr_data, 32'h1234_5678);
        check("wr_last_addr", 32'(last_wr_addr), 32'h1FF);
        cycle();

        // Simultaneous read and write: read only.
        bus_mux_out = 32'h0000_0010; mar_in = 1'b1;
        cycle();
        mar_in = 1'b0;
        read_req = 1'b1; write_req = 1'b1; exp_q.push_back(32'hCAFE_F00D);
        cycle();
        read_req = 1'b0; write_req = 1'b0;
        check("both_c1", {30'h0, mem_re, mem_we}, 32'h2);
        cycle();
        check("both_c2", {30'h0, mem_re, mem_we}, 32'h2);
        cycle();
        check("both_done", {30'h0, done, mem_we}, 32'h2);
        check("both_no_write", 32'(wr_cnt), 32'd2);
        cycle();

        // Lock: MAR/MDR loads ignored while reading 0x010.
        read_req = 1'b1; exp_q.push_back(32'hCAFE_F00D);
        cycle();
        read_req = 1'b0; bus_mux_out = 32'h0000_00AA; mar_in = 1'b1; mdr_in = 1'b1;
        cycle();
        check("lock_addr_c2", 32'(mem_addr), 32'h010);
        check("lock_data_c2", mem_data_out, 32'hCAFE_F00D);
        cycle();
        mar_in = 1'b0; mdr_in = 1'b0;
        check("lock_addr_done", 32'(mem_addr), 32'h010);
        check("lock_mdr", mdr_out, 32'hCAFE_F00D);
        cycle();

        // Back-to-back reads at 0x003 (upper bus bits dropped).
        bus_mux_out = 32'hFFFF_FE03; mar_in = 1'b1;
        cycle();
        mar_in = 1'b0;
        check("b2b_mar", 32'(mem_addr), 32'h003);
        read_req = 1'b1; exp_q.push_back(32'h0000_0333);
        cycle();
        read_req = 1'b0;
        cycle();
        cycle();
        check("b2b_done1", 32'(done), 32'h1);
        ram[9'h003] = 32'h4444_4444;
        read_req = 1'b1; exp_q.push_back(32'h4444_4444);
        cycle();
        read_req = 1'b0;
        check("b2b_accept", {29'h0, busy, done, mem_re}, 32'h5);
        cycle();
        check("b2b_mid", 32'(done), 32'h0);
        cycle();
        check("b2b_done2", {31'h0, done}, 32'h1);
        check("b2b_mdr2", mdr_out, 32'h4444_4444);
        cycle();

        // Clear mid-write aborts with no done pulse.
        bus_mux_out = 32'h0000_0020; mar_in = 1'b1;
        cycle();
        mar_in = 1'b0; bus_mux_out = 32'h55AA_55AA; mdr_in = 1'b1;
        cycle();
        mdr_in = 1'b0; write_req = 1'b1;
        cycle();
        write_req = 1'b0;
        check("clr_pre_we", 32'(mem_we), 32'h1);
        #2;
        clear = 1'b1;
        #1;
        check("clr_we_drop", {29'h0, busy, mem_re, mem_we}, 32'h0);
        check("clr_mar", 32'(mem_addr), 32'h0);
        check("clr_mdr", mdr_out, 32'h0);
        cycle();
        clear = 1'b0;
        repeat (4) cycle();
        check("clr_no_done", 32'(done), 32'h0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory-side front end of the datapath; sits directly upstream of the 512-word RAM.
- Holds the Memory Address Register (MAR) and Memory Data Register (MDR).
- Sequences read/write requests from the control unit into stable RAM address/enable/data signals over a fixed number of wait cycles.
- Captures RAM read data into MDR and drives MDR back onto the bus mux with a one-cycle done pulse.

Parameters:
- DATA_W, 32: bus and MDR width.
- ADDR_W, 9: RAM address width; MAR holds the low ADDR_W bits of the bus.
- WAIT_CYCLES, 2: cycles each RAM access is held. Legal range >=1.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- clear  in  1  asynchronous active-high reset.
- bus_mux_out  in  DATA_W  datapath bus value.
- mar_in  in  1  load MAR from bus_mux_out[ADDR_W-1:0].
- mdr_in  in  1  load MDR from bus_mux_out.
- read_req  in  1  start a RAM read at MAR.
- write_req  in  1  start a RAM write of MDR to MAR.
- mem_data_in  in  DATA_W  read data returned by RAM.
- mem_addr  out  ADDR_W  RAM address; always equals MAR.
- mem_re  out  1  RAM read enable.
- mem_we  out  1  RAM write enable.
- mem_data_out  out  DATA_W  RAM write data; always equals MDR.
- mdr_out  out  DATA_W  MDR contents to the bus mux.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on access completion.

Behaviour:
- Reset (async, immediate):
  - MAR=0, MDR=0, state=IDLE, wait counter=0, done=0.
  - mem_re=0 and mem_we=0 combinationally while clear is high.
  - clear mid-access aborts the access with no MDR capture and no done pulse; the RAM write may be partial.
- States:
  - IDLE: mem_re=0, mem_we=0.
  - RD_ACCESS: mem_re=1, mem_we=0.
  - WR_ACCESS: mem_we=1, mem_re=0.
  - mem_re and mem_we are never high together and are decoded from state only.
- IDLE at a rising edge:
  - mar_in loads MAR. mdr_in loads MDR. Both may assert in the same cycle.
  - read_req: go to RD_ACCESS, counter=WAIT_CYCLES-1.
  - Else write_req: go to WR_ACCESS, counter=WAIT_CYCLES-1.
  - read_req and write_req together: read wins; the write is dropped, not queued.
  - mar_in or mdr_in in the same cycle as a request: the register loads first, and the access uses the new value, because the access starts next cycle from the updated register.
- RD_ACCESS / WR_ACCESS:
  - Stay exactly WAIT_CYCLES cycles; counter decrements each edge.
  - At the edge where counter==0: go to IDLE, done<=1.
  - In RD_ACCESS at that same edge, MDR<=mem_data_in.
  - During access, mar_in, mdr_in, read_req and write_req are ignored. MAR and MDR are frozen so mem_addr and mem_data_out stay stable while enables are high.
- done:
  - High for exactly the first IDLE cycle after an access.
  - On a read, it coincides with mdr_out showing the captured data.
  - A new request sampled in that cycle is accepted, giving back-to-back accesses with one IDLE cycle between them.
- Latency: request sampled at edge 0 -> done high after edge WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+1 cycles.
- Widths: MAR takes bus_mux_out[ADDR_W-1:0]; upper bits are ignored with no wrap or overflow check. mem_data_in is taken full width.
- Counter width is $clog2(WAIT_CYCLES+1); the counter never underflows.

Decomposition:
- Package mem_if_pkg holds:
  - state enum {IDLE, RD_ACCESS, WR_ACCESS}.
  - DATA_W and ADDR_W defaults.
  - Counter-width function.
- One sub-module, mem_reg: a parameterised-width register with async clear and load enable. It is instantiated for MAR (load = mar_in & idle) and MDR (load mux between bus and RAM data, selected by the capture condition).

Test Plan:
1. Assert clear mid-WR_ACCESS -> mem_we drops in the same cycle, MAR=MDR=0, busy=0, no done pulse.
2. Read path: bus=0x0000_0105, mar_in; RAM model returns 0xDEAD_BEEF; read_req at edge 0 with WAIT_CYCLES=2 -> mem_re high 2 cycles at mem_addr=0x105, done high after edge 2, mdr_out=0xDEAD_BEEF.
3. Write path: bus=0x1FF, mar_in; bus=0x1234_5678, mdr_in; write_req -> mem_we high 2 cycles with mem_addr=0x1FF and mem_data_out=0x1234_5678, done pulse, then mem_we=0.
4. Simultaneous requests: read_req and write_req in the same cycle -> RD_ACCESS only, mem_we never asserts.
5. Lock during access: mar_in with bus=0x0AA and mdr_in asserted during RD_ACCESS -> mem_addr unchanged, MDR ends holding RAM data, not bus data.
6. Back-to-back: a new read_req in the done cycle -> accepted, second done exactly 3 cycles after the first; bus=0xFFFF_FE03 into MAR -> mem_addr=0x003.
